// File: rtl/bitwise_accum.sv
// Streaming bitwise reducer: folds a packet of WIDTH-bit words into one word
// with OR/AND/XOR/NOR, valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for the first beat of a packet
// ACCUM | folding further beats into acc until in_last
// HOLD  | result offered on out_*, waiting for out_ready
module bitwise_accum #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic             out_zero
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             sat_q;
  logic [1:0]       op_q;

  // NOR folds as OR; the inversion is applied once on the output side.
  function automatic logic [WIDTH-1:0] fold(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [1:0]       sel);
    case (sel)
      2'b01:   fold = a & b;
      2'b10:   fold = a ^ b;
      default: fold = a | b;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      sat_q <= 1'b0;
      op_q  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= in_data;
            count <= CNT_W'(1);
            sat_q <= 1'b0;
            op_q  <= op;
            state <= in_last ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc <= fold(acc, in_data, op_q);
            if (&count) sat_q <= 1'b1;
            else        count <= count + CNT_W'(1);
            if (in_last) state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            acc   <= '0;
            count <= '0;
            sat_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign out_data  = (op_q == 2'b11) ? ~acc : acc;
  assign out_count = count;
  assign out_sat   = sat_q;
  assign out_zero  = (out_data == '0);

endmodule

// File: tb/tb_bitwise_accum.sv
// Directed bench for bitwise_accum: default instance plus a CNT_W=2 instance
// driven by the same stimulus for the saturation case.
module tb_bitwise_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_sat, out_zero;
  logic [15:0] out_data;
  logic [7:0]  out_count;

  logic        s_in_ready, s_out_valid, s_out_sat, s_out_zero;
  logic [15:0] s_out_data;
  logic [1:0]  s_out_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bitwise_accum #(.WIDTH(16), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_sat(out_sat), .out_zero(out_zero)
  );

  bitwise_accum #(.WIDTH(16), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .in_last(in_last), .op(op),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_count(s_out_count), .out_sat(s_out_sat), .out_zero(s_out_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one beat; called at posedge+1, returns at posedge+1 after the accept.
  task automatic beat(input logic [15:0] d, input logic l, input logic [1:0] o);
    in_valid = 1'b1; in_data = d; in_last = l; op = o;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("consume_valid", 32'(out_valid), 32'd0);
    chk("consume_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [15:0] d,
                              input logic [7:0] c, input logic z);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_inrdy"}, 32'(in_ready), 32'd0);
    chk({tag, "_data"},  32'(out_data), 32'(d));
    chk({tag, "_count"}, 32'(out_count), 32'(c));
    chk({tag, "_zero"},  32'(out_zero), 32'(z));
    chk({tag, "_sat"},   32'(out_sat), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // asynchronous reset mid-cycle with a NOR packet in flight
    beat(16'h1234, 1'b0, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_inrdy", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data), 32'h0000);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_sat",   32'(out_sat), 32'd0);
    chk("rst_zero",  32'(out_zero), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // OR, 2 beats
    beat(16'hAAAA, 1'b0, 2'b00);
    chk("or_early_valid", 32'(out_valid), 32'd0);
    beat(16'h5555, 1'b1, 2'b00);
    check_result("or", 16'hFFFF, 8'd2, 1'b0);
    consume();

    // AND, 3 beats
    beat(16'hFFFF, 1'b0, 2'b01);
    beat(16'h0F0F, 1'b0, 2'b01);
    beat(16'h00FF, 1'b1, 2'b01);
    check_result("and", 16'h000F, 8'd3, 1'b0);
    consume();

    // XOR cancels to zero
    beat(16'h1234, 1'b0, 2'b10);
    beat(16'h1234, 1'b1, 2'b10);
    check_result("xor", 16'h0000, 8'd2, 1'b1);
    consume();

    // NOR single beat
    beat(16'h0000, 1'b1, 2'b11);
    check_result("nor1", 16'hFFFF, 8'd1, 1'b0);
    consume();

    // op change on beat 2 ignored (AND would give 0000)
    beat(16'hF000, 1'b0, 2'b00);
    beat(16'h000F, 1'b1, 2'b01);
    check_result("opchg", 16'hF00F, 8'd2, 1'b0);
    consume();

    // backpressure with a pending beat offered during HOLD
    beat(16'h0001, 1'b0, 2'b00);
    beat(16'h0002, 1'b1, 2'b00);
    in_valid = 1'b1; in_data = 16'h0100; in_last = 1'b1; op = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_result("bp", 16'h0003, 8'd2, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_done_valid", 32'(out_valid), 32'd0);
    chk("bp_done_inrdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    check_result("bp_next", 16'h0100, 8'd1, 1'b0);
    consume();

    // saturation: 5 beats, CNT_W=2 instance saturates, default does not
    beat(16'h0001, 1'b0, 2'b10);
    beat(16'h0002, 1'b0, 2'b10);
    beat(16'h0004, 1'b0, 2'b10);
    beat(16'h0008, 1'b0, 2'b10);
    beat(16'h0010, 1'b1, 2'b10);
    check_result("sat8", 16'h001F, 8'd5, 1'b0);
    chk("sat2_valid", 32'(s_out_valid), 32'd1);
    chk("sat2_inrdy", 32'(s_in_ready), 32'd0);
    chk("sat2_data",  32'(s_out_data), 32'h001F);
    chk("sat2_count", 32'(s_out_count), 32'd3);
    chk("sat2_sat",   32'(s_out_sat), 32'd1);
    chk("sat2_zero",  32'(s_out_zero), 32'd0);
    consume();
    chk("sat2_clear", 32'(s_out_sat), 32'd0);

    // reset after 2 beats discards the partial packet
    beat(16'h1111, 1'b0, 2'b01);
    beat(16'h2222, 1'b0, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(out_valid), 32'd0);
    chk("rstmid_count", 32'(out_count), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_idle", 32'(out_valid), 32'd0);
    beat(16'h00F0, 1'b1, 2'b00);
    check_result("post_rst", 16'h00F0, 8'd1, 1'b0);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/bitwise_accum.md
# bitwise_accum

Parametrised streaming bitwise reduction unit: the sequential successor to the fixed 16-bit two-operand OR gate. It folds a packet of WIDTH-bit words into one word using OR, AND, XOR or NOR. Input and output both use a valid/ready handshake. It sits between a word source (register file or memory read port) and consumers that need whole-packet masks, parity or any-bit-set flags.

## Interface
Parameters:
- WIDTH, 16, data word width in bits (>= 1)
- CNT_W, 8, width of beat counter; counter saturates at 2^CNT_W-1

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input beat offered
- in_ready  output  1  unit can accept a beat this cycle
- in_data  input  WIDTH  input word
- in_last  input  1  marks final beat of a packet
- op  input  2  00 OR, 01 AND, 10 XOR, 11 NOR; sampled only on first beat of packet
- out_valid  output  1  result held and offered
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  reduced word
- out_count  output  CNT_W  beats in packet (saturating)
- out_sat  output  1  beat count overflowed CNT_W
- out_zero  output  1  out_data == 0

## Operation
- Beat accepted when in_valid && in_ready on a rising clk.
- States: IDLE, ACCUM, HOLD.
  - IDLE: in_ready=1, out_valid=0.
    - On accept: acc<=in_data, count<=1, op_q<=op.
    - Next state is HOLD if in_last, else ACCUM.
  - ACCUM: in_ready=1, out_valid=0.
    - On accept: acc<=acc OP in_data (OP = OR for op_q 00 and 11, AND for 01, XOR for 10).
    - count<=count+1, saturating at all-ones; sat_q<=1 if an increment is attempted at all-ones.
    - in_last on an accepted beat moves to HOLD.
    - No accept: hold all state; no timeout.
  - HOLD: in_ready=0, out_valid=1.
    - On out_ready: return to IDLE; acc, count and sat_q clear to 0.
- out_data = ~acc when op_q==11, else acc. out_zero is derived from out_data, not acc.
- op changes after the first beat of a packet are ignored until the next packet.
- in_ready and out_valid are decoded from state only, never combinationally from in_valid or out_ready.
- in_data and in_last are ignored when not accepted.
- Single-beat packet (first beat has in_last=1): result is the word itself, or its inverse for NOR; count 1.
- WIDTH=1 is legal and degenerates to a serial 1-bit reducer.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, acc=0, count=0, sat_q=0, op_q=00.
- Outputs during reset: in_ready=1, out_valid=0, out_data=0, out_count=0, out_sat=0, out_zero=1.
- Reset deassertion: first accept possible on the first rising edge with rst_n high.
- Latency: out_valid rises the cycle after the edge that accepts the in_last beat.
- out_data, out_count, out_sat and out_zero are stable for the whole HOLD state.
- Throughput: one beat per cycle within a packet. One mandatory dead cycle at minimum (HOLD) between packets, because in_ready=0 while out_valid=1.
- Result consumed on the edge where out_ready=1 in HOLD. in_ready returns to 1 the following cycle.
- out_ready asserted outside HOLD has no effect.
- Reset mid-packet or in HOLD: partial or unconsumed result is discarded with no output.

## Test plan
- Reset check: reset asserted asynchronously mid-cycle -> in_ready=1, out_valid=0, out_data=0000, out_zero=1 immediately.
- OR, 2 beats, WIDTH=16: AAAA then 5555 (last), op=00 -> out_data=FFFF, out_count=2, out_zero=0. out_valid rises one cycle after the 2nd accept.
- AND, 3 beats: FFFF, 0F0F, 00FF (last), op=01 -> out_data=000F.
- XOR: 1234, 1234 (last), op=10 -> out_data=0000, out_zero=1.
- NOR, single beat: 0000 with last, op=11 -> out_data=FFFF, out_count=1.
- Op change mid-packet is ignored: op toggled 00->01 on beat 2 -> OR result still produced.
- Backpressure: out_ready low 5 cycles -> out_valid, out_data and out_count held, in_ready=0 throughout. New packet accepted one cycle after the consume edge.
- Saturation, CNT_W=2: 5 beats -> out_count=3, out_sat=1.
- Reset mid-packet after 2 beats: no output. A following single-beat 00F0 with op=00 -> out_data=00F0, out_count=1.
